apb4_regfile_slave: RTL

//  Parametrised APB4 slave exposing NREGS read/write data registers to the bus.

---
 rtl/apb4_regfile_slave.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/apb4_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb4_regfile_slave
//   APB4 slave exposing NREGS read/write data registers. Supports byte
//   strobes, a fixed number of wait states per transfer and PSLVERR for
//   bad addresses or strobed reads. Register contents are also driven out in
//   parallel (regs_o), one cycle after the write completes.
//
// Ports
//   PCLK     in   clock, rising edge
//   PRESET   in   asynchronous reset, active-high
//   PSEL     in   slave select
//   PENABLE  in   access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address
//   PWDATA   in   write data
//   PSTRB    in   write byte enables
//   PRDATA   out  read data, non-zero only on a successful read with PREADY
//   PREADY   out  transfer completes this cycle
//   PSLVERR  out  error response, only with PREADY
//   regs_o   out  flattened registers, reg i = regs_o[i*DATA_WIDTH +: DATA_WIDTH]
// ---------------------------------------------------------------------------
module apb4_regfile_slave #(
  parameter int                       DATA_WIDTH  = 32,
  parameter int                       ADDR_WIDTH  = 32,
  parameter int                       NREGS       = 16,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR   = '0,
  parameter int                       WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0]    REG_RESET   = '0
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [ADDR_WIDTH-1:0]         PADDR,
  input  logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH/8-1:0]       PSTRB,
  output logic [DATA_WIDTH-1:0]         PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  output logic [NREGS*DATA_WIDTH-1:0]   regs_o
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);

  // One-hot IDLE/ACCESS encoding shared with the other bus slaves.
  typedef enum logic [1:0] {
    IDLE   = 2'b01,
    ACCESS = 2'b10
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // -------------------------------------------------------------------------
  // Address decode (purely combinational on the current bus signals)
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic                  addr_below;
  logic                  misalign;
  logic                  out_of_range;
  logic                  strb_on_read;
  logic                  dec_err;
  logic [NREGS-1:0]      wr_sel;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [NREGS*DATA_WIDTH-1:0] regs_flat;

  always_comb begin
    off          = PADDR - BASE_ADDR;
    idx_full     = off >> LSB;
    addr_below   = (PADDR < BASE_ADDR);
    misalign     = ((off & ALIGN_MASK) != '0);
    out_of_range = (idx_full >= ADDR_WIDTH'(NREGS));
    strb_on_read = !PWRITE && (PSTRB != '0);
    dec_err      = addr_below | misalign | out_of_range | strb_on_read;
  end

  // Full-width index compare avoids truncating the decoded index, so an
  // out-of-range offset can never alias onto a real register.
  always_comb begin
    wr_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx_full == ADDR_WIDTH'(i)) begin
        wr_sel[i] = 1'b1;
        rd_mux    = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic xfer_done;
  logic wr_fire;

  always_comb begin
    PREADY    = (state_q == ACCESS) && (cnt_q == 4'd0);
    xfer_done = PREADY && PSEL && PENABLE;
    wr_fire   = xfer_done && PWRITE && !dec_err;
    PSLVERR   = PREADY && dec_err;
    PRDATA    = (PREADY && !PWRITE && !dec_err) ? rd_mux : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // Only a proper setup phase starts a transfer; a stray PENABLE
        // without the preceding setup cycle is ignored.
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer: no update, no response.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (PENABLE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Register storage. out_q is a one-cycle delayed copy that feeds regs_o.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] reg_q, reg_d, out_q;

    always_comb begin
      reg_d = reg_q;
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_fire && wr_sel[gi] && PSTRB[b]) begin
          reg_d[b*8 +: 8] = PWDATA[b*8 +: 8];
        end
      end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
        reg_q <= REG_RESET;
        out_q <= REG_RESET;
      end else begin
        reg_q <= reg_d;
        out_q <= reg_q;
      end
    end

    assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
    assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH]    = out_q;
  end

endmodule
